// File: rtl/axi_lite_mem_master_if.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_master_if
//   Bundles the CPU-side simple memory port and the AXI4-Lite master channels
//   used by axi_lite_mem_master.
//   master modport : the bridge (drives AXI requests and CPU completions)
//   slave  modport : the environment (CPU requester plus AXI slave)
//   CPU side : mem_rd_en, mem_wr_en, mem_is_fetch, mem_addr, mem_wr_data,
//              mem_wr_strb -> bridge ; mem_rd_ready, mem_rd_data,
//              mem_wr_done, mem_err <- bridge
//   AXI side : AW, W, B, AR, R channels (m_* signals)
// ---------------------------------------------------------------------------
interface axi_lite_mem_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU memory port
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              mem_is_fetch;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [3:0]        mem_wr_strb;
  logic              mem_rd_ready;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_done;
  logic              mem_err;

  // AXI4-Lite master channels
  logic [ADDR_W-1:0] m_awaddr;
  logic [2:0]        m_awprot;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [ADDR_W-1:0] m_araddr;
  logic [2:0]        m_arprot;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    input  mem_rd_en, mem_wr_en, mem_is_fetch, mem_addr, mem_wr_data, mem_wr_strb,
    output mem_rd_ready, mem_rd_data, mem_wr_done, mem_err,
    output m_awaddr, m_awprot, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arprot, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    output mem_rd_en, mem_wr_en, mem_is_fetch, mem_addr, mem_wr_data, mem_wr_strb,
    input  mem_rd_ready, mem_rd_data, mem_wr_done, mem_err,
    input  m_awaddr, m_awprot, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arprot, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/axi_lite_mem_master.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_master
//   Bridges a level-enabled CPU memory port onto one AXI4-Lite master with a
//   single outstanding transaction. Every AXI and CPU-side output is a flop.
//   Ports:
//     clock   : single clock
//     reset_n : asynchronous active-low reset
//     bus     : axi_lite_mem_master_if.master (CPU port + AXI channels)
// ---------------------------------------------------------------------------
module axi_lite_mem_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          clock,
  input  logic                          reset_n,
  axi_lite_mem_master_if.master         bus
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [2:0]        arprot_q, arprot_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              rd_ready_q, rd_ready_d;
  logic              wr_done_q, wr_done_d;
  logic              err_pulse_q, err_pulse_d;

  // The bus is word addressed; the byte offset is deliberately discarded.
  logic [ADDR_W-1:0] word_addr;
  logic              addr_lsb_unused;
  assign word_addr       = {bus.mem_addr[ADDR_W-1:2], 2'b00};
  assign addr_lsb_unused = ^bus.mem_addr[1:0];

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    err_d       = err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    araddr_d    = araddr_q;
    awaddr_d    = awaddr_q;
    arprot_d    = arprot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        // Writes win when both enables are high.
        if (bus.mem_wr_en) begin
          awaddr_d  = word_addr;
          wdata_d   = bus.mem_wr_data;
          wstrb_d   = bus.mem_wr_strb;
          is_wr_d   = 1'b1;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_REQ;
        end else if (bus.mem_rd_en) begin
          araddr_d  = word_addr;
          arprot_d  = {bus.mem_is_fetch, 2'b00};
          is_wr_d   = 1'b0;
          err_d     = 1'b0;
          state_d   = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && bus.m_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rready_q && bus.m_rvalid) begin
          rdata_d = bus.m_rdata;
          err_d   = (bus.m_rresp != 2'b00);
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or together.
        if (awvalid_q && bus.m_awready) aw_done_d = 1'b1;
        if (wvalid_q && bus.m_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)      state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (bready_q && bus.m_bvalid) begin
          err_d   = (bus.m_bresp != 2'b00);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Handshake and pulse outputs are registered copies of what the next
    // state implies, so no AXI input reaches an output combinationally.
    arvalid_d   = (state_d == RD_ADDR);
    rready_d    = (state_d == RD_DATA);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    rd_ready_d  = (state_d == DONE) && !is_wr_d;
    wr_done_d   = (state_d == DONE) && is_wr_d;
    err_pulse_d = (state_d == DONE) && err_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      err_q       <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      arprot_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rd_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      err_q       <= err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      araddr_q    <= araddr_d;
      awaddr_q    <= awaddr_d;
      arprot_q    <= arprot_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rd_ready_q  <= rd_ready_d;
      wr_done_q   <= wr_done_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.m_awaddr     = awaddr_q;
  assign bus.m_awprot     = 3'b000;
  assign bus.m_awvalid    = awvalid_q;
  assign bus.m_wdata      = wdata_q;
  assign bus.m_wstrb      = wstrb_q;
  assign bus.m_wvalid     = wvalid_q;
  assign bus.m_bready     = bready_q;
  assign bus.m_araddr     = araddr_q;
  assign bus.m_arprot     = arprot_q;
  assign bus.m_arvalid    = arvalid_q;
  assign bus.m_rready     = rready_q;
  assign bus.mem_rd_ready = rd_ready_q;
  assign bus.mem_rd_data  = rdata_q;
  assign bus.mem_wr_done  = wr_done_q;
  assign bus.mem_err      = err_pulse_q;

endmodule

// File: tb/tb_axi_lite_mem_master.sv
module tb_axi_lite_mem_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  axi_lite_mem_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  axi_lite_mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  // slave configuration (written by test tasks only)
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [1:0]  cfg_bresp = 2'b00;

  // monitor state (written by monitor only)
  bit          r_pend, b_pend, aw_seen, w_seen;
  int          proto_err = 0, ar_hs_cnt = 0, arvalid_hi_cnt = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arprot, cap_awprot;
  logic [3:0]  cap_wstrb;

  // AXI slave: drives ready/valid on the falling edge
  initial begin
    int ar_w, aw_w, w_w, r_w, b_w;
    ar_w = 0; aw_w = 0; w_w = 0; r_w = 0; b_w = 0;
    ifc.m_arready = 0; ifc.m_awready = 0; ifc.m_wready = 0;
    ifc.m_rvalid = 0; ifc.m_rdata = '0; ifc.m_rresp = 2'b00;
    ifc.m_bvalid = 0; ifc.m_bresp = 2'b00;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        ifc.m_arready = 0; ifc.m_awready = 0; ifc.m_wready = 0;
        ifc.m_rvalid = 0; ifc.m_bvalid = 0;
        ar_w = 0; aw_w = 0; w_w = 0; r_w = 0; b_w = 0;
      end else begin
        if (ifc.m_arvalid) begin ifc.m_arready = (ar_w >= ar_delay); ar_w++; end
        else begin ifc.m_arready = 0; ar_w = 0; end
        if (ifc.m_awvalid) begin ifc.m_awready = (aw_w >= aw_delay); aw_w++; end
        else begin ifc.m_awready = 0; aw_w = 0; end
        if (ifc.m_wvalid) begin ifc.m_wready = (w_w >= w_delay); w_w++; end
        else begin ifc.m_wready = 0; w_w = 0; end
        if (r_pend) begin
          ifc.m_rvalid = (r_w >= r_delay); ifc.m_rdata = cfg_rdata; ifc.m_rresp = cfg_rresp; r_w++;
        end else begin ifc.m_rvalid = 0; r_w = 0; end
        if (b_pend) begin
          ifc.m_bvalid = (b_w >= b_delay); ifc.m_bresp = cfg_bresp; b_w++;
        end else begin ifc.m_bvalid = 0; b_w = 0; end
      end
    end
  end

  // Protocol monitor: samples pre-edge values on the rising edge
  initial begin
    bit ar_hold, aw_hold, w_hold, ar_drop, aw_drop, w_drop;
    logic [31:0] h_araddr, h_awaddr, h_wdata;
    logic [3:0]  h_wstrb;
    ar_hold = 0; aw_hold = 0; w_hold = 0; ar_drop = 0; aw_drop = 0; w_drop = 0;
    h_araddr = '0; h_awaddr = '0; h_wdata = '0; h_wstrb = '0;
    r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
        ar_hold = 0; aw_hold = 0; w_hold = 0; ar_drop = 0; aw_drop = 0; w_drop = 0;
      end else begin
        if (ar_hold && (!ifc.m_arvalid || ifc.m_araddr !== h_araddr)) proto_err++;
        if (aw_hold && (!ifc.m_awvalid || ifc.m_awaddr !== h_awaddr)) proto_err++;
        if (w_hold && (!ifc.m_wvalid || ifc.m_wdata !== h_wdata || ifc.m_wstrb !== h_wstrb)) proto_err++;
        if ((ar_drop && ifc.m_arvalid) || (aw_drop && ifc.m_awvalid) || (w_drop && ifc.m_wvalid)) proto_err++;
        if (ifc.m_rready && !r_pend) proto_err++;
        if (ifc.m_bready && !b_pend) proto_err++;
        if (ifc.m_arvalid) arvalid_hi_cnt++;
        ar_hold = ifc.m_arvalid && !ifc.m_arready; h_araddr = ifc.m_araddr;
        aw_hold = ifc.m_awvalid && !ifc.m_awready; h_awaddr = ifc.m_awaddr;
        w_hold  = ifc.m_wvalid && !ifc.m_wready;   h_wdata = ifc.m_wdata; h_wstrb = ifc.m_wstrb;
        ar_drop = ifc.m_arvalid && ifc.m_arready;
        aw_drop = ifc.m_awvalid && ifc.m_awready;
        w_drop  = ifc.m_wvalid && ifc.m_wready;
        if (ifc.m_arvalid && ifc.m_arready) begin
          ar_hs_cnt++; r_pend = 1; cap_araddr = ifc.m_araddr; cap_arprot = ifc.m_arprot;
        end
        if (ifc.m_rvalid && ifc.m_rready) r_pend = 0;
        if (ifc.m_awvalid && ifc.m_awready) begin
          aw_seen = 1; cap_awaddr = ifc.m_awaddr; cap_awprot = ifc.m_awprot;
        end
        if (ifc.m_wvalid && ifc.m_wready) begin
          w_seen = 1; cap_wdata = ifc.m_wdata; cap_wstrb = ifc.m_wstrb;
        end
        if (aw_seen && w_seen) begin b_pend = 1; aw_seen = 0; w_seen = 0; end
        if (ifc.m_bvalid && ifc.m_bready) b_pend = 0;
      end
    end
  end

  // Waits for a completion pulse; cyc counts rising edges until it is seen.
  task automatic wait_pulse(input int max_cyc, output int cyc, output bit timed_out);
    cyc = 0;
    timed_out = 1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clock); #1;
      cyc++;
      if (ifc.mem_rd_ready || ifc.mem_wr_done) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({ifc.m_arvalid, ifc.m_rready, ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b want 00000",
        {ifc.m_arvalid, ifc.m_rready, ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready});
    end
    n_cmp++;
    if ({ifc.mem_rd_ready, ifc.mem_wr_done, ifc.mem_err} !== 3'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000", {ifc.mem_rd_ready, ifc.mem_wr_done, ifc.mem_err});
    end
    n_cmp++;
    if ({ifc.mem_rd_data, ifc.m_araddr, ifc.m_awaddr, ifc.m_wdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want zeros",
        ifc.mem_rd_data, ifc.m_araddr, ifc.m_awaddr, ifc.m_wdata);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_read_zero_wait();
    int cyc; bit to; exp_t e; int pe0;
    repeat (2) @(negedge clock);
    pe0 = proto_err;
    ar_delay = 0; r_delay = 0; cfg_rdata = 32'hDEADBEEF; cfg_rresp = 2'b00;
    ifc.mem_addr = 32'h0000_1003; ifc.mem_is_fetch = 1'b1; ifc.mem_rd_en = 1'b1;
    sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    @(posedge clock); #1;
    n_cmp++;
    if (ifc.m_arvalid !== 1'b1 || ifc.m_araddr !== 32'h0000_1000) begin
      n_fail++; $display("FAIL rd_ar_issue: arvalid=%b araddr=%h want 1 00001000", ifc.m_arvalid, ifc.m_araddr);
    end
    n_cmp++;
    if (ifc.m_arprot !== 3'b100) begin
      n_fail++; $display("FAIL rd_arprot_fetch: got %b want 100", ifc.m_arprot);
    end
    wait_pulse(50, cyc, to);
    ifc.mem_rd_en = 1'b0; ifc.mem_is_fetch = 1'b0;
    n_cmp++;
    if (to || cyc + 1 != 3) begin
      n_fail++; $display("FAIL rd_latency: got %0d (timeout=%0d) want 3", cyc + 1, to);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({ifc.mem_wr_done, ifc.mem_rd_ready} !== {e.is_wr, !e.is_wr} || ifc.mem_rd_data !== e.data || ifc.mem_err !== e.err) begin
      n_fail++; $display("FAIL rd_result: wr_done=%b rd_ready=%b data=%h err=%b want rd pulse data=%h err=%b",
        ifc.mem_wr_done, ifc.mem_rd_ready, ifc.mem_rd_data, ifc.mem_err, e.data, e.err);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (ifc.mem_rd_ready !== 1'b0 || ifc.mem_rd_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_pulse_width: rd_ready=%b data=%h want 0 deadbeef", ifc.mem_rd_ready, ifc.mem_rd_data);
    end
    n_cmp++;
    if (proto_err !== pe0) begin
      n_fail++; $display("FAIL rd_protocol: violations=%0d want 0", proto_err - pe0);
    end
  endtask

  task automatic test_write_skew();
    int cyc; bit to; exp_t e; int pe0;
    repeat (2) @(negedge clock);
    pe0 = proto_err;
    aw_delay = 3; w_delay = 0; b_delay = 2; cfg_bresp = 2'b00;
    ifc.mem_addr = 32'h0000_2006; ifc.mem_wr_data = 32'h1234_5678; ifc.mem_wr_strb = 4'b0011;
    ifc.mem_wr_en = 1'b1;
    sb.push_back('{1'b1, 32'h1234_5678, 1'b0});
    @(posedge clock); #1;
    n_cmp++;
    if ({ifc.m_awvalid, ifc.m_wvalid} !== 2'b11) begin
      n_fail++; $display("FAIL wr_valids_on_entry: got %b want 11", {ifc.m_awvalid, ifc.m_wvalid});
    end
    @(posedge clock); #1;
    n_cmp++;
    if ({ifc.m_awvalid, ifc.m_wvalid} !== 2'b10) begin
      n_fail++; $display("FAIL wr_w_drops_first: got %b want 10", {ifc.m_awvalid, ifc.m_wvalid});
    end
    wait_pulse(50, cyc, to);
    ifc.mem_wr_en = 1'b0;
    n_cmp++;
    if (to || cyc + 2 != 8) begin
      n_fail++; $display("FAIL wr_latency: got %0d (timeout=%0d) want 8", cyc + 2, to);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({ifc.mem_wr_done, ifc.mem_rd_ready} !== {e.is_wr, !e.is_wr} || ifc.mem_err !== e.err) begin
      n_fail++; $display("FAIL wr_result: wr_done=%b rd_ready=%b err=%b want wr pulse err=%b",
        ifc.mem_wr_done, ifc.mem_rd_ready, ifc.mem_err, e.err);
    end
    n_cmp++;
    if (cap_awaddr !== 32'h0000_2004 || cap_awprot !== 3'b000 || cap_wdata !== e.data || cap_wstrb !== 4'b0011) begin
      n_fail++; $display("FAIL wr_payload: awaddr=%h awprot=%b wdata=%h wstrb=%b want 00002004 000 %h 0011",
        cap_awaddr, cap_awprot, cap_wdata, cap_wstrb, e.data);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (ifc.mem_wr_done !== 1'b0) begin
      n_fail++; $display("FAIL wr_pulse_width: got %b want 0", ifc.mem_wr_done);
    end
    n_cmp++;
    if (proto_err !== pe0) begin
      n_fail++; $display("FAIL wr_protocol: violations=%0d want 0", proto_err - pe0);
    end
    aw_delay = 0; b_delay = 0;
  endtask

  task automatic test_wr_rd_priority();
    int cyc; bit to; exp_t e; int ar0;
    repeat (2) @(negedge clock);
    ar0 = ar_hs_cnt;
    cfg_rdata = 32'hCAFE_0042; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    ifc.mem_addr = 32'h0000_3000; ifc.mem_wr_data = 32'h0BAD_F00D; ifc.mem_wr_strb = 4'hF;
    ifc.mem_wr_en = 1'b1; ifc.mem_rd_en = 1'b1;
    sb.push_back('{1'b1, 32'h0BAD_F00D, 1'b0});
    sb.push_back('{1'b0, 32'hCAFE_0042, 1'b0});
    wait_pulse(50, cyc, to);
    ifc.mem_wr_en = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (to || {ifc.mem_wr_done, ifc.mem_rd_ready} !== {e.is_wr, !e.is_wr} || cap_wdata !== e.data) begin
      n_fail++; $display("FAIL prio_write_first: wr_done=%b rd_ready=%b wdata=%h timeout=%0d want write %h",
        ifc.mem_wr_done, ifc.mem_rd_ready, cap_wdata, to, e.data);
    end
    n_cmp++;
    if (ar_hs_cnt !== ar0) begin
      n_fail++; $display("FAIL prio_no_ar_during_write: ar handshakes=%0d want 0", ar_hs_cnt - ar0);
    end
    wait_pulse(50, cyc, to);
    ifc.mem_rd_en = 1'b0;
    n_cmp++;
    if (to || cyc != 4) begin
      n_fail++; $display("FAIL prio_read_follows: cycles=%0d (timeout=%0d) want 4", cyc, to);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({ifc.mem_wr_done, ifc.mem_rd_ready} !== {e.is_wr, !e.is_wr} || ifc.mem_rd_data !== e.data || cap_araddr !== 32'h0000_3000) begin
      n_fail++; $display("FAIL prio_read_result: rd_ready=%b data=%h araddr=%h want 1 %h 00003000",
        ifc.mem_rd_ready, ifc.mem_rd_data, cap_araddr, e.data);
    end
  endtask

  task automatic test_error();
    int cyc; bit to; exp_t e;
    repeat (2) @(negedge clock);
    cfg_rdata = 32'hA5A5_0001; cfg_rresp = 2'b10;
    ifc.mem_addr = 32'h0000_0040; ifc.mem_rd_en = 1'b1;
    sb.push_back('{1'b0, 32'hA5A5_0001, 1'b1});
    wait_pulse(50, cyc, to);
    ifc.mem_rd_en = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (to || ifc.mem_rd_ready !== 1'b1 || ifc.mem_err !== e.err || ifc.mem_rd_data !== e.data) begin
      n_fail++; $display("FAIL err_read: rd_ready=%b err=%b data=%h timeout=%0d want 1 %b %h",
        ifc.mem_rd_ready, ifc.mem_err, ifc.mem_rd_data, to, e.err, e.data);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (ifc.mem_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse_width: got %b want 0", ifc.mem_err);
    end
    repeat (2) @(negedge clock);
    cfg_bresp = 2'b11;
    ifc.mem_addr = 32'h0000_0044; ifc.mem_wr_data = 32'h0000_0001; ifc.mem_wr_strb = 4'hF;
    ifc.mem_wr_en = 1'b1;
    sb.push_back('{1'b1, 32'h0000_0001, 1'b1});
    wait_pulse(50, cyc, to);
    ifc.mem_wr_en = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (to || ifc.mem_wr_done !== 1'b1 || ifc.mem_err !== e.err) begin
      n_fail++; $display("FAIL err_write: wr_done=%b err=%b timeout=%0d want 1 %b",
        ifc.mem_wr_done, ifc.mem_err, to, e.err);
    end
    cfg_rresp = 2'b00; cfg_bresp = 2'b00;
  endtask

  task automatic test_backpressure();
    int cyc; bit to; exp_t e; int pe0, hi0;
    repeat (2) @(negedge clock);
    pe0 = proto_err; hi0 = arvalid_hi_cnt;
    ar_delay = 5; r_delay = 0; cfg_rdata = 32'h7777_0000;
    ifc.mem_addr = 32'h0000_5008; ifc.mem_rd_en = 1'b1;
    sb.push_back('{1'b0, 32'h7777_0000, 1'b0});
    wait_pulse(50, cyc, to);
    ifc.mem_rd_en = 1'b0;
    n_cmp++;
    if (to || cyc != 8) begin
      n_fail++; $display("FAIL bp_latency: got %0d (timeout=%0d) want 8", cyc, to);
    end
    n_cmp++;
    if (arvalid_hi_cnt - hi0 != 6 || cap_araddr !== 32'h0000_5008) begin
      n_fail++; $display("FAIL bp_arvalid_cycles: cycles=%0d araddr=%h want 6 00005008", arvalid_hi_cnt - hi0, cap_araddr);
    end
    n_cmp++;
    if (proto_err !== pe0) begin
      n_fail++; $display("FAIL bp_protocol: violations=%0d want 0", proto_err - pe0);
    end
    e = sb.pop_front();
    n_cmp++;
    if (ifc.mem_rd_data !== e.data || ifc.mem_err !== e.err) begin
      n_fail++; $display("FAIL bp_data: data=%h err=%b want %h %b", ifc.mem_rd_data, ifc.mem_err, e.data, e.err);
    end
    ar_delay = 0;
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; exp_t e; bit seen;
    repeat (2) @(negedge clock);
    r_delay = 20; cfg_rdata = 32'h1111_2222;
    ifc.mem_addr = 32'h0000_6000; ifc.mem_rd_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (ifc.m_rready) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL rstmid_reach_rd_data: rready=%b want 1", ifc.m_rready);
    end
    @(negedge clock); #2;
    reset_n = 1'b0; ifc.mem_rd_en = 1'b0;
    #1;
    n_cmp++;
    if ({ifc.m_arvalid, ifc.m_rready, ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready,
         ifc.mem_rd_ready, ifc.mem_wr_done, ifc.mem_err} !== 8'b0) begin
      n_fail++; $display("FAIL rstmid_async_clear: got %b want 00000000",
        {ifc.m_arvalid, ifc.m_rready, ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready,
         ifc.mem_rd_ready, ifc.mem_wr_done, ifc.mem_err});
    end
    n_cmp++;
    if (ifc.mem_rd_data !== 32'h0 || ifc.m_araddr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_data_clear: rd_data=%h araddr=%h want 0 0", ifc.mem_rd_data, ifc.m_araddr);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    r_delay = 0; cfg_rdata = 32'h3333_4444;
    repeat (2) @(negedge clock);
    ifc.mem_addr = 32'h0000_6004; ifc.mem_rd_en = 1'b1;
    sb.push_back('{1'b0, 32'h3333_4444, 1'b0});
    wait_pulse(50, cyc, to);
    ifc.mem_rd_en = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (to || cyc != 3 || ifc.mem_rd_data !== e.data) begin
      n_fail++; $display("FAIL rstmid_recover: cycles=%0d data=%h timeout=%0d want 3 %h", cyc, ifc.mem_rd_data, to, e.data);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; exp_t e;
    repeat (2) @(negedge clock);
    cfg_rdata = 32'h0000_00B1;
    ifc.mem_addr = 32'h0000_7000; ifc.mem_rd_en = 1'b1;
    sb.push_back('{1'b0, 32'h0000_00B1, 1'b0});
    wait_pulse(50, cyc, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || ifc.mem_rd_data !== e.data) begin
      n_fail++; $display("FAIL b2b_first: data=%h timeout=%0d want %h", ifc.mem_rd_data, to, e.data);
    end
    ifc.mem_addr = 32'h0000_7010; cfg_rdata = 32'h0000_00B2;
    sb.push_back('{1'b0, 32'h0000_00B2, 1'b0});
    wait_pulse(50, cyc, to);
    ifc.mem_rd_en = 1'b0;
    n_cmp++;
    if (to || cyc != 4) begin
      n_fail++; $display("FAIL b2b_spacing: cycles=%0d (timeout=%0d) want 4", cyc, to);
    end
    e = sb.pop_front();
    n_cmp++;
    if (ifc.mem_rd_data !== e.data || cap_araddr !== 32'h0000_7010) begin
      n_fail++; $display("FAIL b2b_second: data=%h araddr=%h want %h 00007010", ifc.mem_rd_data, cap_araddr, e.data);
    end
  endtask

  initial begin
    ifc.mem_rd_en = 0; ifc.mem_wr_en = 0; ifc.mem_is_fetch = 0;
    ifc.mem_addr = '0; ifc.mem_wr_data = '0; ifc.mem_wr_strb = '0;
    test_reset();
    test_read_zero_wait();
    test_write_skew();
    test_wr_rd_priority();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
